dmem_banked_ctrl: RTL

Parametrised data-memory controller that replaces the fixed 32x32 single-port data memory in the processor's MEM stage.
- Data width and depth are configurable.
- Byte, halfword and word loads and stores use byte-lane enables and sign/zero extension.
- A valid/ready request channel feeds a fixed-latency response pipeline.
- After reset, a clear sequence zeroes the whole array before any request is accepted.

---
 rtl/dmem_banked_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_banked_ctrl.sv
// Parametrised data-memory controller: byte/half/word access, clear-on-reset, fixed-latency responses.
// Optional per-lane even parity storage and checking is enabled by defining DMEM_PARITY_EN.
module dmem_banked_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
`ifdef DMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              err;
  logic [1:0]        off;
  logic [ADDR_W-1:0] widx;
  logic [LANES-1:0]  wmask;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rd_word;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return o[0];
      2'b10:   return (o != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00:   return LANES'(1) << o;
      2'b01:   return LANES'(3) << o;
      default: return '1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] o,
                                                    input logic [1:0] size,
                                                    input logic sgn);
    logic [DATA_W-1:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {o, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   return sgn ? DATA_W'(b) : DATA_W'(sh[7:0]);
      2'b01:   return sgn ? DATA_W'(h) : DATA_W'(sh[15:0]);
      default: return sh;
    endcase
  endfunction

  assign off      = req_addr[1:0];
  assign widx     = req_addr[ADDR_W+1:2];
  assign err      = misaligned(req_size, off);
  assign wmask    = lane_mask(req_size, off);
  assign wdata_sh = req_wdata << {off, 3'b000};
  assign rd_word  = mem[widx];
  assign acc      = req_valid & req_ready & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_nxt = READY;
      READY:   req_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  // Array write: a store lands at its accepting edge so the next load sees it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (acc && req_we && !err) begin
        for (int l = 0; l < LANES; l++)
          if (wmask[l]) mem[widx][8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [LANES-1:0] par [DEPTH];
  logic             rd_par_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        par[clr_cnt] <= '0;
      end else if (acc && req_we && !err) begin
        for (int l = 0; l < LANES; l++)
          if (wmask[l]) par[widx][l] <= ^wdata_sh[8*l +: 8];
      end
    end
  end

  always_comb begin
    rd_par_bad = 1'b0;
    for (int l = 0; l < LANES; l++)
      rd_par_bad = rd_par_bad | ((^rd_word[8*l +: 8]) ^ par[widx][l]);
  end
`endif

  // Stage p0: response captured at the accepting edge
  logic              vld_p0;
  logic              err_p0;
  logic [DATA_W-1:0] rdata_p0;
`ifdef DMEM_PARITY_EN
  logic              perr_p0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      err_p0   <= 1'b0;
      rdata_p0 <= '0;
`ifdef DMEM_PARITY_EN
      perr_p0  <= 1'b0;
`endif
    end else begin
      vld_p0   <= acc;
      err_p0   <= acc & err;
      rdata_p0 <= (acc && !err && !req_we) ? extend_load(rd_word, off, req_size, req_signed) : '0;
`ifdef DMEM_PARITY_EN
      perr_p0  <= acc & ~err & ~req_we & rd_par_bad;
`endif
    end
  end

  // Stage p1: extra delay slot when two cycles of latency are configured
  if (READ_LAT == 2) begin : g_lat2
    logic              vld_p1;
    logic              err_p1;
    logic [DATA_W-1:0] rdata_p1;
`ifdef DMEM_PARITY_EN
    logic              perr_p1;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1   <= 1'b0;
        err_p1   <= 1'b0;
        rdata_p1 <= '0;
`ifdef DMEM_PARITY_EN
        perr_p1  <= 1'b0;
`endif
      end else begin
        vld_p1   <= vld_p0;
        err_p1   <= err_p0;
        rdata_p1 <= rdata_p0;
`ifdef DMEM_PARITY_EN
        perr_p1  <= perr_p0;
`endif
      end
    end

    assign resp_valid = vld_p1;
    assign resp_err   = err_p1;
    assign resp_rdata = rdata_p1;
`ifdef DMEM_PARITY_EN
    assign parity_err = perr_p1;
`endif
  end else begin : g_lat1
    assign resp_valid = vld_p0;
    assign resp_err   = err_p0;
    assign resp_rdata = rdata_p0;
`ifdef DMEM_PARITY_EN
    assign parity_err = perr_p0;
`endif
  end

endmodule
